cm_row_counter_update: RTL

CM_ROW_COUNTER_UPDATE -- requirements
Module: cm_row_counter_update

---
 rtl/cm_row_counter_update.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cm_row_counter_update.sv
// One count-min sketch row: read-increment-write counter update with same-index forwarding and a full-row clear sequencer.
// Optional build macro CM_SAT_COUNT_EN: saturating counters plus a sticky sat_seen output.
module cm_row_counter_update #(
  parameter int W         = 4096,
  parameter int HASH_SIZE = $clog2(W),
  parameter int CNT_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [HASH_SIZE-1:0] in_idx,
  output logic                 in_ready,
  input  logic                 clear_req,
  output logic                 out_valid,
  output logic [HASH_SIZE-1:0] out_idx,
  output logic [CNT_SIZE-1:0]  out_cnt,
  output logic                 busy
`ifdef CM_SAT_COUNT_EN
  ,
  output logic                 sat_seen
`endif
);

  typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;

  localparam logic [HASH_SIZE-1:0] LAST_ADDR = HASH_SIZE'(W - 1);

  state_t                state;
  logic [HASH_SIZE-1:0]  clr_ptr;
  logic [CNT_SIZE-1:0]   mem [W];

  logic                  vld_p1;
  logic [HASH_SIZE-1:0]  idx_p1;
  logic [CNT_SIZE-1:0]   rd_p1;

  logic                  vld_p2;
  logic [HASH_SIZE-1:0]  idx_p2;
  logic [CNT_SIZE-1:0]   cnt_p2;

  logic                  accept;
  logic [CNT_SIZE-1:0]   base_p1;
  logic [CNT_SIZE-1:0]   new_p1;
  logic                  we;
  logic [HASH_SIZE-1:0]  waddr;
  logic [CNT_SIZE-1:0]   wdata;

  function automatic logic [CNT_SIZE-1:0] incr_cnt(input logic [CNT_SIZE-1:0] b);
`ifdef CM_SAT_COUNT_EN
    return (&b) ? b : b + CNT_SIZE'(1);
`else
    return b + CNT_SIZE'(1);
`endif
  endfunction

  assign in_ready = (state == RUN);
  assign busy     = (state != RUN);
  assign accept   = in_valid && in_ready;

  // S1 -> S2: the RAM cannot yet hold the previous update to this index, so take it from S2
  assign base_p1 = (vld_p2 && (idx_p2 == idx_p1)) ? cnt_p2 : rd_p1;
  assign new_p1  = incr_cnt(base_p1);

  always_comb begin
    we    = 1'b0;
    waddr = idx_p1;
    wdata = new_p1;
    if (state == CLEAR) begin
      we    = 1'b1;
      waddr = clr_ptr;
      wdata = '0;
    end else if (vld_p1) begin
      we = 1'b1;
    end
  end

  // Counter RAM: synchronous read returns old data on a same-address write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (accept) begin
      rd_p1  <= mem[in_idx];
      idx_p1 <= in_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      idx_p2  <= '0;
      cnt_p2  <= '0;
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        idx_p2 <= idx_p1;
        cnt_p2 <= new_p1;
      end
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + HASH_SIZE'(1);
          if (clr_ptr == LAST_ADDR) state <= RUN;
        end
        RUN: begin
          if (clear_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!vld_p1 && !vld_p2) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

`ifdef CM_SAT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_seen <= 1'b0;
    end else if (state == DRAIN && !vld_p1 && !vld_p2) begin
      sat_seen <= 1'b0;
    end else if (vld_p1 && (&base_p1)) begin
      sat_seen <= 1'b1;
    end
  end
`endif

  assign out_valid = vld_p2;
  assign out_idx   = idx_p2;
  assign out_cnt   = cnt_p2;

endmodule
